// File: rtl/riscv_types.sv
// Shared RISC-V trace types: the buffered RVFI record layout and the serializer state encoding.
package riscv_types;

    localparam int RVFI_WORDS_PER_REC = 9;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rs3_rdata;
        logic [31:0] rd_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rs3_addr;
        logic [4:0]  rd_addr;
        logic [7:0]  seq;
        logic [15:0] drops;
    } rvfi_rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; a push into a full FIFO is honoured only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rvfi_trace_packer.sv
// Buffers retired-instruction RVFI records and streams each as nine 32-bit words,
// counting records lost to a full buffer and reporting the gap in the next header.
module rvfi_trace_packer
    import riscv_types::*;
#(
    parameter int         DEPTH = 8,
    parameter logic [7:0] MAGIC = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rvfi_valid,
    input  logic [31:0]               rvfi_insn,
    input  logic [31:0]               rvfi_pc_rdata,
    input  logic [31:0]               rvfi_pc_wdata,
    input  logic [31:0]               rvfi_rs1_rdata,
    input  logic [31:0]               rvfi_rs2_rdata,
    input  logic [31:0]               rvfi_rs3_rdata,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic [4:0]                rvfi_rs1_addr,
    input  logic [4:0]                rvfi_rs2_addr,
    input  logic [4:0]                rvfi_rs3_addr,
    input  logic [4:0]                rvfi_rd_addr,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [31:0]               m_data,
    output logic                      m_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               drop_total
);
    localparam int         LW        = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAST_WIDX = 4'(RVFI_WORDS_PER_REC - 1);

    ser_state_t  state;
    logic [3:0]  widx;
    logic [7:0]  seq;
    logic [15:0] pend_drops;
    rvfi_rec_t   wr_rec;
    rvfi_rec_t   head;
    logic        full;
    logic        empty;
    logic [LW-1:0] level;
    logic        handshake;
    logic        pop;
    logic        push;
    logic        drop;
    logic        busy_next;

    assign wr_rec = '{
        insn:      rvfi_insn,
        pc_rdata:  rvfi_pc_rdata,
        pc_wdata:  rvfi_pc_wdata,
        rs1_rdata: rvfi_rs1_rdata,
        rs2_rdata: rvfi_rs2_rdata,
        rs3_rdata: rvfi_rs3_rdata,
        rd_wdata:  rvfi_rd_wdata,
        rs1_addr:  rvfi_rs1_addr,
        rs2_addr:  rvfi_rs2_addr,
        rs3_addr:  rvfi_rs3_addr,
        rd_addr:   rvfi_rd_addr,
        seq:       seq,
        drops:     pend_drops
    };

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rvfi_rec_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_rec),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign m_valid    = (state == ST_SEND);
    assign m_last     = m_valid && (widx == LAST_WIDX);
    assign handshake  = m_valid && m_ready;
    assign pop        = handshake && (widx == LAST_WIDX);
    assign push       = rvfi_valid && (!full || pop);
    assign drop       = rvfi_valid && full && !pop;
    assign fifo_level = level;

    // The state mirrors FIFO occupancy after this edge's push/pop.
    assign busy_next  = push || !(empty || (pop && level == LW'(1)));

    always_comb begin
        m_data = '0;
        if (m_valid) begin
            case (widx)
                4'd0:    m_data = {MAGIC, head.seq, head.drops};
                4'd1:    m_data = head.insn;
                4'd2:    m_data = head.pc_rdata;
                4'd3:    m_data = head.pc_wdata;
                4'd4:    m_data = head.rs1_rdata;
                4'd5:    m_data = head.rs2_rdata;
                4'd6:    m_data = head.rs3_rdata;
                4'd7:    m_data = head.rd_wdata;
                4'd8:    m_data = {12'b0, head.rd_addr, head.rs3_addr, head.rs2_addr, head.rs1_addr};
                default: m_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            widx       <= '0;
            seq        <= '0;
            pend_drops <= '0;
            drop_total <= '0;
        end else begin
            state <= busy_next ? ST_SEND : ST_IDLE;
            if (handshake) widx <= pop ? 4'd0 : widx + 4'd1;
            if (push) begin
                seq        <= seq + 8'd1;
                pend_drops <= '0;
            end else if (drop) begin
                if (pend_drops != 16'hFFFF) pend_drops <= pend_drops + 16'd1;
                if (drop_total != 16'hFFFF) drop_total <= drop_total + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_trace_packer.sv
// Self-checking bench for rvfi_trace_packer: fixed vectors, corner sequences and a random run against a queue model.
module tb_rvfi_trace_packer;
    import riscv_types::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        rvfi_valid;
    logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic [3:0]  fifo_level;
    logic [15:0] drop_total;

    rvfi_trace_packer #(.DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
        .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid),
        .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs3_addr(rvfi_rs3_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .fifo_level(fifo_level), .drop_total(drop_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference: a queue of records plus the word position within the head.
    rvfi_rec_t   q[$];
    int          widx_m;
    logic [7:0]  seq_m;
    int          pend_m;
    int          total_m;
    logic [31:0] hdr_seen;

    typedef struct {
        rvfi_rec_t         rec;
        logic [8:0][31:0]  words;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input rvfi_rec_t r, input int k);
        logic [31:0] w;
        case (k)
            0: w = {8'hA5, r.seq, r.drops};
            1: w = r.insn;
            2: w = r.pc_rdata;
            3: w = r.pc_wdata;
            4: w = r.rs1_rdata;
            5: w = r.rs2_rdata;
            6: w = r.rs3_rdata;
            7: w = r.rd_wdata;
            default: w = 32'(r.rs1_addr) + (32'(r.rs2_addr) << 5) + (32'(r.rs3_addr) << 10)
                         + (32'(r.rd_addr) << 15);
        endcase
        return w;
    endfunction

    function automatic rvfi_rec_t mk(input logic [31:0] insn, pcr, pcw, r1, r2, r3, rdw,
                                     input logic [4:0] a1, a2, a3, ad);
        rvfi_rec_t r;
        r = '0;
        r.insn = insn; r.pc_rdata = pcr; r.pc_wdata = pcw;
        r.rs1_rdata = r1; r.rs2_rdata = r2; r.rs3_rdata = r3; r.rd_wdata = rdw;
        r.rs1_addr = a1; r.rs2_addr = a2; r.rs3_addr = a3; r.rd_addr = ad;
        return r;
    endfunction

    function automatic rvfi_rec_t rand_rec();
        return mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endfunction

    task automatic model_clear();
        q.delete();
        widx_m = 0; seq_m = 8'd0; pend_m = 0; total_m = 0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance model and DUT together.
    task automatic step(input logic rst, input logic v, input rvfi_rec_t r, input logic rdy);
        logic full_pre, hs, popm;
        rvfi_rec_t e;
        reset = rst; rvfi_valid = v; m_ready = rdy;
        rvfi_insn = r.insn; rvfi_pc_rdata = r.pc_rdata; rvfi_pc_wdata = r.pc_wdata;
        rvfi_rs1_rdata = r.rs1_rdata; rvfi_rs2_rdata = r.rs2_rdata;
        rvfi_rs3_rdata = r.rs3_rdata; rvfi_rd_wdata = r.rd_wdata;
        rvfi_rs1_addr = r.rs1_addr; rvfi_rs2_addr = r.rs2_addr;
        rvfi_rs3_addr = r.rs3_addr; rvfi_rd_addr = r.rd_addr;
        #1;
        chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("m_data", m_data, exp_word(q[0], widx_m));
            chk("m_last", 32'(m_last), 32'(widx_m == 8));
        end else begin
            chk("m_data_idle", m_data, 32'h0);
            chk("m_last_idle", 32'(m_last), 32'h0);
        end
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("drop_total", 32'(drop_total), 32'(total_m));
        if (rst) begin
            model_clear();
        end else begin
            full_pre = (q.size() == DEPTH);
            hs   = (q.size() > 0) && rdy;
            popm = hs && (widx_m == 8);
            if (hs && widx_m == 0) hdr_seen = m_data;
            if (popm) begin
                void'(q.pop_front());
                widx_m = 0;
            end else if (hs) begin
                widx_m++;
            end
            if (v) begin
                if (!full_pre || popm) begin
                    e = r; e.seq = seq_m; e.drops = 16'(pend_m);
                    q.push_back(e);
                    seq_m++;
                    pend_m = 0;
                end else begin
                    if (pend_m < 65535) pend_m++;
                    if (total_m < 65535) total_m++;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    rvfi_rec_t idle;
    rvfi_rec_t bp_rec;

    initial begin
        idle = '0;
        tbl[0].rec = mk(32'h00A00093, 32'h100, 32'h104, 0, 0, 0, 32'hA, 5'd0, 5'd0, 5'd0, 5'd1);
        tbl[0].words = {32'h00008000, 32'h0000000A, 32'h0, 32'h0, 32'h0,
                        32'h00000104, 32'h00000100, 32'h00A00093, 32'hA5000000};
        tbl[1].rec = mk(32'h002081B3, 32'h104, 32'h108, 32'h5, 32'h7, 0, 32'hC, 5'd1, 5'd2, 5'd0, 5'd3);
        tbl[1].words = {32'h00018041, 32'h0000000C, 32'h0, 32'h00000007, 32'h00000005,
                        32'h00000108, 32'h00000104, 32'h002081B3, 32'hA5010000};
        tbl[2].rec = mk(32'hFFFFFFFF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h11111111, 32'h22222222,
                        32'h33333333, 32'h44444444, 5'd31, 5'd31, 5'd31, 5'd31);
        tbl[2].words = {32'h000FFFFF, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111,
                        32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hA5020000};

        reset = 1'b1; rvfi_valid = 1'b0; m_ready = 1'b0;
        rvfi_insn = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
        rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0; rvfi_rs3_rdata = '0; rvfi_rd_wdata = '0;
        rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rs3_addr = '0; rvfi_rd_addr = '0;
        hdr_seen = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_fifo_level", 32'(fifo_level), 32'h0);
        chk("rst_drop_total", 32'(drop_total), 32'h0);
        step(1'b0, 1'b0, idle, 1'b1);

        // Fixed vectors: word sequence on consecutive cycles after capture.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, tbl[i].rec, 1'b1);
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("vec%0d_word%0d", i, k), m_data, tbl[i].words[k]);
                chk($sformatf("vec%0d_last%0d", i, k), 32'(m_last), 32'(k == 8));
                step(1'b0, 1'b0, idle, 1'b1);
            end
        end

        // Back-pressure at word 3: pc_wdata must stay on the bus.
        bp_rec = tbl[0].rec;
        step(1'b0, 1'b1, bp_rec, 1'b1);
        repeat (3) step(1'b0, 1'b0, idle, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", m_data, 32'h00000104);
            step(1'b0, 1'b0, idle, 1'b0);
        end
        chk("bp_after_hold", m_data, 32'h00000104);
        repeat (6) step(1'b0, 1'b0, idle, 1'b1);

        // Overflow, then a push coinciding with the final-word pop of a full FIFO.
        step(1'b1, 1'b0, idle, 1'b0);
        repeat (11) step(1'b0, 1'b1, rand_rec(), 1'b0);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_drops", 32'(drop_total), 32'd3);
        repeat (8) step(1'b0, 1'b0, idle, 1'b1);
        step(1'b0, 1'b1, rand_rec(), 1'b1);
        chk("fullpop_level", 32'(fifo_level), 32'd8);
        chk("fullpop_drops", 32'(drop_total), 32'd3);
        repeat (72) step(1'b0, 1'b0, idle, 1'b1);
        chk("ovf_hdr", hdr_seen, 32'hA5080003);

        // Sequence wrap over 257 back-to-back records.
        step(1'b1, 1'b0, idle, 1'b0);
        for (int i = 0; i < 257; i++) begin
            step(1'b0, 1'b1, rand_rec(), 1'b1);
            repeat (8) step(1'b0, 1'b0, idle, 1'b1);
        end
        step(1'b0, 1'b0, idle, 1'b1);
        chk("wrap_hdr", hdr_seen, 32'hA5000000);

        // Reset in the middle of a record.
        step(1'b1, 1'b0, idle, 1'b0);
        repeat (3) step(1'b0, 1'b1, rand_rec(), 1'b0);
        repeat (5) step(1'b0, 1'b0, idle, 1'b1);
        step(1'b1, 1'b0, idle, 1'b1);
        chk("midrst_valid", 32'(m_valid), 32'h0);
        chk("midrst_level", 32'(fifo_level), 32'h0);
        step(1'b0, 1'b1, rand_rec(), 1'b0);
        chk("midrst_hdr", m_data, 32'hA5000000);
        step(1'b1, 1'b0, idle, 1'b0);

        // Random traffic: heavy load with drops, then light load.
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0),
                 rand_rec(), $urandom_range(0, 9) < 6);
        end
        repeat (80) step(1'b0, 1'b0, idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
